multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and write-back, and drives every datapath select: the 5-bit register-destination mux, the 32-bit ALU-source muxes, the memory-to-register mux and the PC-source mux. It also folds the branch AND (PC write condition with ALU zero) into one PC enable. Supported instructions are R-type, lw, sw, beq, j and addi. Memory access stalls on a ready handshake.

---
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select; outputs decode from the state register, gated by mem_ready and zero.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal_op;
    logic   w_illegal;
    logic   w_pc_write;
    logic   w_pc_write_cond;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    assign w_illegal  = (r_state == S_DECODE) && !op_is_legal(opcode);
    assign state      = r_state;
    assign illegal_op = r_illegal_op;

    // State register and the one-cycle illegal-opcode flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_illegal_op <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_illegal_op <= w_illegal;
        end
    end

    // Next-state selection; the opcode is consulted in DECODE and again in MEM_ADDR
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:    w_next_state = S_EXECUTE;
                    OP_LW:   w_next_state = S_MEM_ADDR;
                    OP_SW:   w_next_state = S_MEM_ADDR;
                    OP_BEQ:  w_next_state = S_BRANCH;
                    OP_J:    w_next_state = S_JUMP;
                    OP_ADDI: w_next_state = S_ADDI_EX;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: w_next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            S_ADDI_EX:   w_next_state = S_ADDI_WB;
            S_ADDI_WB:   w_next_state = S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; unlisted controls stay 0, including the unused encodings
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        ior_d           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        instr_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE:    alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                ior_d      = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
                instr_done      = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
        pc_en = w_pc_write | (w_pc_write_cond & zero);
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model (state path per opcode,
// stall states, per-state control table) is compared against the DUT every cycle under random stimulus.
module tb_multicycle_control;
    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    typedef struct packed {
        logic       pc_en;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    ctl_t obs;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_ill = 1'b0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ior_d(ior_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    assign obs = {pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, instr_done};

    function automatic bit legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    // Stall-free cycle count of one instruction
    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            OP_R, OP_SW, OP_ADDI: return 4;
            OP_LW:                return 5;
            OP_BEQ, OP_J:         return 3;
            default:              return 2;
        endcase
    endfunction

    // Control values the datapath needs in each step of an instruction
    function automatic ctl_t exp_ctl(input int st, input bit mr, input bit z);
        ctl_t e;
        e = '0;
        case (st)
            0:  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1'b1; e.ior_d = 1'b1; end
            4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
            5:  begin e.mem_write = 1'b1; e.ior_d = 1'b1; e.instr_done = mr; end
            6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
            8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_en = z; e.pc_source = 2'b01; e.instr_done = 1'b1; end
            9:  begin e.pc_en = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1; end
            10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            11: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Runs one instruction from FETCH; nf/nm = not-ready cycles in FETCH / memory step; zmode 2 = random zero
    task automatic run_instr(input logic [5:0] op, input int nf, input int nm, input int zmode, output int cycles);
        int p[$];
        p = {0, 1};
        case (op)
            OP_R:    begin p.push_back(6); p.push_back(7); end
            OP_LW:   begin p.push_back(2); p.push_back(3); p.push_back(4); end
            OP_SW:   begin p.push_back(2); p.push_back(5); end
            OP_BEQ:  p.push_back(8);
            OP_J:    p.push_back(9);
            OP_ADDI: begin p.push_back(10); p.push_back(11); end
            default: ;
        endcase
        cycles = 0;
        foreach (p[i]) begin
            int   n;
            ctl_t e;
            n = (p[i] == 0) ? nf : ((p[i] == 3 || p[i] == 5) ? nm : 0);
            for (int k = 0; k <= n; k++) begin
                opcode    = (p[i] == 0) ? 6'($urandom_range(0, 63)) : op;
                mem_ready = (n == 0) ? ((p[i] == 0 || p[i] == 3 || p[i] == 5) ? 1'b1 : 1'($urandom_range(0, 1)))
                                     : (k == n);
                zero      = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
                #1;
                e = exp_ctl(p[i], mem_ready, zero);
                n_cmp++;
                if (state !== 4'(p[i]) || obs !== e || illegal_op !== exp_ill) begin
                    n_err++;
                    $display("FAIL step op=%b: state=%0d ctl=%h illegal_op=%b, expected state=%0d ctl=%h illegal_op=%b",
                             op, state, obs, illegal_op, p[i], e, exp_ill);
                end
                @(posedge clock);
                #1;
                cycles++;
                exp_ill = (p[i] == 1) && !legal(op);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = OP_LW; zero = 1'b0;
        #2;
        n_cmp++;
        if (state !== 4'd0 || obs !== exp_ctl(0, 1'b0, 1'b0) || illegal_op !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d ctl=%h illegal=%b, expected 0 %h 0", state, obs, illegal_op, exp_ctl(0, 1'b0, 1'b0));
        end
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
            n_err++;
            $display("FAIL reset_held: state=%0d ir_write=%b pc_en=%b, expected 0 1 1", state, ir_write, pc_en);
        end
        reset = 1'b0;
        exp_ill = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c;
        opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++;
        if (state !== 4'd3 || mem_read !== 1'b1 || ior_d !== 1'b1) begin
            n_err++;
            $display("FAIL mem_read_stall: state=%0d mem_read=%b ior_d=%b, expected 3 1 1", state, mem_read, ior_d);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'd0 || mem_read !== 1'b1 || ior_d !== 1'b0 || reg_write !== 1'b0 || illegal_op !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: state=%0d mem_read=%b ior_d=%b reg_write=%b illegal=%b, expected 0 1 0 0 0",
                     state, mem_read, ior_d, reg_write, illegal_op);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        exp_ill = 1'b0;
        run_instr(6'b111111, 0, 0, 2, c);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (illegal_op !== 1'b0 || state !== 4'd0) begin
            n_err++;
            $display("FAIL reset_clears_illegal: illegal_op=%b state=%0d, expected 0 0", illegal_op, state);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        exp_ill = 1'b0;
    endtask

    task automatic test_lw();
        int c;
        run_instr(OP_LW, 0, 0, 2, c);
        n_cmp++;
        if (c !== 5) begin n_err++; $display("FAIL lw_cycles: got %0d, expected 5", c); end
    endtask

    task automatic test_sw_stall();
        int c;
        run_instr(OP_SW, 0, 3, 2, c);
        n_cmp++;
        if (c !== 7) begin n_err++; $display("FAIL sw_stall_cycles: got %0d, expected 7", c); end
    endtask

    task automatic test_beq();
        int c1, c0;
        run_instr(OP_BEQ, 0, 0, 1, c1);
        run_instr(OP_BEQ, 0, 0, 0, c0);
        n_cmp++;
        if (c1 !== 3 || c0 !== 3) begin n_err++; $display("FAIL beq_cycles: got %0d/%0d, expected 3/3", c1, c0); end
    endtask

    task automatic test_back_to_back();
        int cr, cj;
        run_instr(OP_R, 0, 0, 2, cr);
        run_instr(OP_J, 0, 0, 2, cj);
        n_cmp++;
        if (cr !== 4 || cj !== 3) begin n_err++; $display("FAIL rtype_j_cycles: got %0d/%0d, expected 4/3", cr, cj); end
    endtask

    task automatic test_illegal_fetch_stall();
        int ci, ca;
        run_instr(6'b111111, 0, 0, 2, ci);
        run_instr(OP_ADDI, 2, 0, 2, ca);
        n_cmp++;
        if (ci !== 2 || ca !== 6) begin n_err++; $display("FAIL illegal_stall_cycles: got %0d/%0d, expected 2/6", ci, ca); end
    endtask

    task automatic test_random();
        logic [5:0] ops [0:5];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        for (int t = 0; t < 60; t++) begin
            logic [5:0] op;
            int nf, nm, c, want;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
            nf = $urandom_range(0, 3);
            nm = $urandom_range(0, 3);
            want = base_cycles(op) + nf + ((legal(op) && (op == OP_LW || op == OP_SW)) ? nm : 0);
            run_instr(op, nf, nm, 2, c);
            n_cmp++;
            if (c !== want) begin n_err++; $display("FAIL random_cycles op=%b: got %0d, expected %0d", op, c, want); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_lw();
        test_sw_stall();
        test_beq();
        test_back_to_back();
        test_illegal_fetch_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
